// File: rtl/tx_msg_driver.sv
// Message-buffer transmit driver: streams buffered characters to a UART one at a time,
// waiting for acceptance, re-issuing on timeout, with optional continuous looping.
module tx_msg_driver #(
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned ACK_TIMEOUT = 1024,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned LW          = $clog2(DEPTH + 1)
) (
    input  logic              Enable,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [AW-1:0]     WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Start,
    input  logic [LW-1:0]     MsgLen,
    input  logic              Repeat,
    input  logic              Abort,
    input  logic              TxEmpty,
    output logic              XMitGo,
    output logic [DATA_W-1:0] TxData,
    output logic [AW-1:0]     Address,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]     len_q, len_d;
    logic              rpt_q, rpt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic              xmit_q, xmit_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              len_ok_c;
    logic              last_c;

    // Buffer survives reset and is frozen while a message is in flight.
    always_ff @(posedge Enable) begin
        if (WrEn && (state_q == IDLE)) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    always_ff @(posedge Enable or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            rpt_q   <= 1'b0;
            addr_q  <= '0;
            txd_q   <= '0;
            xmit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rpt_q   <= rpt_d;
            addr_q  <= addr_d;
            txd_q   <= txd_d;
            xmit_q  <= xmit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign len_ok_c = (MsgLen != '0) && (MsgLen <= LW'(DEPTH));
    assign last_c   = (LW'(addr_q) == (len_q - LW'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rpt_d   = rpt_q;
        addr_d  = addr_q;
        txd_d   = txd_q;
        xmit_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;

        // Abort wins over everything, including completion on the same edge.
        if (Abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && len_ok_c) begin
                        len_d   = MsgLen;
                        rpt_d   = Repeat;
                        addr_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (TxEmpty) begin
                        xmit_d  = 1'b1;
                        txd_d   = mem_q[addr_q];
                        tmo_d   = '0;
                        state_d = ACK;
                    end
                end
                ACK: begin
                    if (!TxEmpty) begin
                        tmo_d = '0;
                        if (!last_c) begin
                            addr_d  = addr_q + AW'(1);
                            state_d = ISSUE;
                        end else if (rpt_q) begin
                            addr_d  = '0;
                            state_d = ISSUE;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        // UART never took the character: re-issue it.
                        tmo_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign XMitGo  = xmit_q;
    assign TxData  = txd_q;
    assign Address = addr_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_tx_msg_driver.sv
// Directed bench for tx_msg_driver with a simple UART acceptance model.
module tb_tx_msg_driver;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TMO    = 1024;
    localparam int unsigned AW     = 4;
    localparam int unsigned LW     = 5;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              WrEn = 1'b0;
    logic [AW-1:0]     WrAddr = '0;
    logic [DATA_W-1:0] WrData = '0;
    logic              Start = 1'b0;
    logic [LW-1:0]     MsgLen = '0;
    logic              Repeat = 1'b0;
    logic              Abort = 1'b0;
    logic              TxEmpty;
    logic              XMitGo;
    logic [DATA_W-1:0] TxData;
    logic [AW-1:0]     Address;
    logic              Busy;
    logic              Done;

    tx_msg_driver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .Enable (clk),
        .Reset  (Reset),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .Start  (Start),
        .MsgLen (MsgLen),
        .Repeat (Repeat),
        .Abort  (Abort),
        .TxEmpty(TxEmpty),
        .XMitGo (XMitGo),
        .TxData (TxData),
        .Address(Address),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    logic [7:0] msg [0:12] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h57,
                               8'h4F, 8'h52, 8'h4C, 8'h44, 8'h0D, 8'h0A};

    int n_pass  = 0;
    int n_total = 0;

    // UART model: one cycle after XMitGo, holding register reads full for 8 cycles.
    logic        uart_drop = 1'b0;
    int unsigned drop_cnt  = 0;
    always @(posedge clk) begin
        if (uart_drop && XMitGo) drop_cnt <= 8;
        else if (drop_cnt != 0)  drop_cnt <= drop_cnt - 1;
    end
    assign TxEmpty = (drop_cnt == 0);

    int         cyc = 0;
    logic [7:0] xd [$];
    logic [3:0] xa [$];
    int         xc [$];
    int         done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!Reset) begin
            if (XMitGo) begin
                xd.push_back(TxData);
                xa.push_back(Address);
                xc.push_back(cyc);
            end
            if (Done) done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        xd.delete();
        xa.delete();
        xc.delete();
        done_cnt = 0;
    endtask

    task automatic start_msg(input int len, input logic rpt);
        Start  = 1'b1;
        MsgLen = LW'(len);
        Repeat = rpt;
        tick();
        Start  = 1'b0;
    endtask

    task automatic wait_xmit(input int n, input int bound);
        for (int k = 0; k < bound && xd.size() < n; k++) tick();
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound && done_cnt == 0; k++) tick();
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_xmit", 32'(XMitGo), 32'd0);
        check("rst_txdata", 32'(TxData), 32'd0);
        check("rst_addr", 32'(Address), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            WrEn = 1'b1; WrAddr = AW'(i); WrData = msg[i];
            tick();
        end
        WrEn = 1'b0;

        // Illegal lengths are ignored
        clear_log();
        start_msg(0, 1'b0);
        check("len0_busy", 32'(Busy), 32'd0);
        start_msg(DEPTH + 1, 1'b0);
        check("len17_busy", 32'(Busy), 32'd0);
        tick(5);
        check("badlen_xmits", 32'(xd.size()), 32'd0);
        check("badlen_done", 32'(done_cnt), 32'd0);

        // Single-shot HELLO WORLD, with a write attempted while busy
        uart_drop = 1'b1;
        clear_log();
        start_msg(13, 1'b0);
        check("one_busy", 32'(Busy), 32'd1);
        WrEn = 1'b1; WrAddr = '0; WrData = 8'h5A;
        tick();
        WrEn = 1'b0;
        wait_done(400);
        check("one_done_seen", 32'(done_cnt), 32'd1);
        check("one_xmits", 32'(xd.size()), 32'd13);
        for (int i = 0; i < 13 && i < xd.size(); i++) begin
            check($sformatf("one_data%0d", i), 32'(xd[i]), 32'(msg[i]));
            check($sformatf("one_addr%0d", i), 32'(xa[i]), 32'(i));
        end
        check("one_busy_end", 32'(Busy), 32'd0);
        tick(20);
        check("one_done_once", 32'(done_cnt), 32'd1);
        check("one_no_extra", 32'(xd.size()), 32'd13);

        // Repeat mode wraps to 'H' (original, not 5A); abort after 20 chars
        clear_log();
        start_msg(13, 1'b1);
        wait_xmit(20, 600);
        check("rep_xmits", 32'(xd.size()), 32'd20);
        for (int i = 13; i < 20 && i < xd.size(); i++) begin
            check($sformatf("rep_data%0d", i), 32'(xd[i]), 32'(msg[i-13]));
            check($sformatf("rep_addr%0d", i), 32'(xa[i]), 32'(i - 13));
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_xmit", 32'(XMitGo), 32'd0);
        tick(30);
        check("abort_no_more", 32'(xd.size()), 32'd20);
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // UART never accepts: same char re-issued every TMO+1 cycles
        uart_drop = 1'b0;
        tick(10);
        clear_log();
        start_msg(3, 1'b0);
        wait_xmit(3, 4000);
        check("tmo_xmits", 32'(xd.size()), 32'd3);
        for (int i = 0; i < 3 && i < xd.size(); i++) begin
            check($sformatf("tmo_data%0d", i), 32'(xd[i]), 32'h48);
            check($sformatf("tmo_addr%0d", i), 32'(xa[i]), 32'd0);
        end
        for (int i = 1; i < 3 && i < xc.size(); i++)
            check($sformatf("tmo_gap%0d", i), 32'(xc[i] - xc[i-1]), 32'(TMO + 1));
        Abort = 1'b1;
        tick();
        Abort = 1'b0;

        // Asynchronous reset mid-message
        uart_drop = 1'b1;
        clear_log();
        start_msg(13, 1'b0);
        wait_xmit(3, 200);
        check("ar_pre_xmits", 32'(xd.size()), 32'd3);
        @(posedge clk);
        #3;
        Reset = 1'b1;
        #1;
        check("ar_xmit", 32'(XMitGo), 32'd0);
        check("ar_txdata", 32'(TxData), 32'd0);
        check("ar_addr", 32'(Address), 32'd0);
        check("ar_busy", 32'(Busy), 32'd0);
        check("ar_done", 32'(Done), 32'd0);
        tick(2);
        Reset = 1'b0;
        clear_log();
        tick(15);
        check("ar_idle_busy", 32'(Busy), 32'd0);
        check("ar_idle_xmits", 32'(xd.size()), 32'd0);
        start_msg(2, 1'b0);
        wait_done(200);
        check("ar_new_done", 32'(done_cnt), 32'd1);
        check("ar_new_xmits", 32'(xd.size()), 32'd2);
        if (xd.size() >= 2) begin
            check("ar_new_d0", 32'(xd[0]), 32'h48);
            check("ar_new_a0", 32'(xa[0]), 32'd0);
            check("ar_new_d1", 32'(xd[1]), 32'h45);
            check("ar_new_a1", 32'(xa[1]), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
